// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : shared hazard-control definitions (entry layout, fwd codes)
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

    localparam int HZ_RAW = 5;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_LOAD = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [HZ_RAW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic [HZ_RAW-1:0] rs1;
        logic [HZ_RAW-1:0] rs2;
        logic              rs1_used;
        logic              rs2_used;
    } hz_entry_t;

    localparam int HZ_ENTRY_W = $bits(hz_entry_t);

    // x0 is hard-wired zero, so it can never be a forwarding source.
    function automatic logic is_producer(input hz_entry_t e);
        return e.valid && e.regwrite && (e.rd != '0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [HZ_RAW-1:0] src,
                                           input logic              used,
                                           input hz_entry_t         mem,
                                           input hz_entry_t         wb,
                                           input logic              load_fwd);
        logic [1:0] sel;
        sel = FWD_RF;
        if (used) begin
            if (is_producer(mem) && (mem.rd == src)) begin
                sel = (mem.memread && load_fwd) ? FWD_LOAD : FWD_MEM;
            end else if (is_producer(wb) && (wb.rd == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_stage.sv
// ============================================================================
// hz_stage_reg : one shadow-pipeline entry with hold, bubble-flush and reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module hz_stage_reg
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic [HZ_ENTRY_W-1:0] d_i,
    output logic [HZ_ENTRY_W-1:0] q_o
);

    logic [HZ_ENTRY_W-1:0] entry_q;
    logic [HZ_ENTRY_W-1:0] entry_d;

    // Hold wins over flush: a stalled EX unit freezes even a pending bubble.
    always_comb begin
        entry_d = entry_q;
        if (hold_i) begin
            entry_d = entry_q;
        end else if (flush_i) begin
            entry_d = '0;
        end else begin
            entry_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush/forwarding control for a 5-stage in-order pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int CNT_W    = 16,
    parameter int LOAD_FWD = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              ex_redirect_i,
    input  logic              ex_busy_i,
    output logic              pc_hold_o,
    output logic              ifid_hold_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              exmem_hold_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    hz_entry_t w_id_entry;
    hz_entry_t w_ex;
    hz_entry_t w_mem;
    hz_entry_t w_wb;

    logic w_load_use;
    logic w_busy;
    logic w_redirect;
    logic w_lu_stall;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        w_id_entry          = '0;
        w_id_entry.valid    = id_valid_i;
        w_id_entry.rd       = HZ_RAW'(id_rd_i);
        w_id_entry.regwrite = id_regwrite_i;
        w_id_entry.memread  = id_memread_i;
        w_id_entry.rs1      = HZ_RAW'(id_rs1_i);
        w_id_entry.rs2      = HZ_RAW'(id_rs2_i);
        w_id_entry.rs1_used = id_rs1_used_i;
        w_id_entry.rs2_used = id_rs2_used_i;
    end

    assign w_load_use = (LOAD_FWD == 0) && id_valid_i && is_producer(w_ex) && w_ex.memread
                        && ((id_rs1_used_i && (w_ex.rd == w_id_entry.rs1))
                         || (id_rs2_used_i && (w_ex.rd == w_id_entry.rs2)));

    // Priority: busy freezes everything, then redirect, then load-use.
    assign w_busy     = ex_busy_i;
    assign w_redirect = ex_redirect_i && !ex_busy_i;
    assign w_lu_stall = w_load_use && !ex_redirect_i && !ex_busy_i;

    assign pc_hold_o    = w_busy || w_lu_stall;
    assign ifid_hold_o  = w_busy || w_lu_stall;
    assign ifid_flush_o = w_redirect;
    assign idex_flush_o = w_redirect || w_lu_stall;
    assign exmem_hold_o = w_busy;

    assign fwd_a_o = fwd_sel(w_ex.rs1, w_ex.rs1_used, w_mem, w_wb, LOAD_FWD != 0);
    assign fwd_b_o = fwd_sel(w_ex.rs2, w_ex.rs2_used, w_mem, w_wb, LOAD_FWD != 0);

    hz_stage_reg u_ex (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .hold_i  (w_busy),
        .flush_i (w_redirect || w_lu_stall || !id_valid_i),
        .d_i     (w_id_entry),
        .q_o     (w_ex)
    );

    hz_stage_reg u_mem (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .hold_i  (w_busy),
        .flush_i (1'b0),
        .d_i     (w_ex),
        .q_o     (w_mem)
    );

    hz_stage_reg u_wb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .hold_i  (w_busy),
        .flush_i (1'b0),
        .d_i     (w_mem),
        .q_o     (w_wb)
    );

    // Source fields of the older entries are carried only for debug visibility.
    logic w_unused_fields;
    assign w_unused_fields = ^{w_mem.rs1, w_mem.rs2, w_mem.rs1_used, w_mem.rs2_used,
                               w_wb.rs1, w_wb.rs2, w_wb.rs1_used, w_wb.rs2_used, w_wb.memread};

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((w_busy || w_lu_stall) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (w_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, ex_busy;

    logic       pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] stall_cnt, flush_cnt;

    logic        pc_hold2, ifid_hold2, ifid_flush2, idex_flush2, exmem_hold2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [15:0] stall_cnt2, flush_cnt2;

    logic [4:0] ctrl, ctrl2;
    assign ctrl  = {pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold};
    assign ctrl2 = {pc_hold2, ifid_hold2, ifid_flush2, idex_flush2, exmem_hold2};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(3), .LOAD_FWD(0)) dut (
        .clk_i(clk), .reset_i(reset),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .ex_redirect_i(ex_redirect), .ex_busy_i(ex_busy),
        .pc_hold_o(pc_hold), .ifid_hold_o(ifid_hold), .ifid_flush_o(ifid_flush),
        .idex_flush_o(idex_flush), .exmem_hold_o(exmem_hold),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .LOAD_FWD(1)) dut_lf (
        .clk_i(clk), .reset_i(reset),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .ex_redirect_i(ex_redirect), .ex_busy_i(ex_busy),
        .pc_hold_o(pc_hold2), .ifid_hold_o(ifid_hold2), .ifid_flush_o(ifid_flush2),
        .idex_flush_o(idex_flush2), .exmem_hold_o(exmem_hold2),
        .fwd_a_o(fwd_a2), .fwd_b_o(fwd_b2),
        .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = '0; id_regwrite = 1'b0; id_memread = 1'b0;
        ex_redirect = 1'b0; ex_busy = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        n_checks++;
        if (ctrl !== 5'b00000) begin n_errors++; $display("FAIL reset_ctrl got=%b exp=00000", ctrl); end
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin n_errors++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
        n_checks++;
        if ({stall_cnt, flush_cnt} !== 6'd0) begin n_errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_load_use;
        do_reset();
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);           // lw x5
        tick();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);           // add x6,x5,x1
        #1;
        n_checks++;
        if (ctrl !== 5'b11010) begin n_errors++; $display("FAIL lu_stall_ctrl got=%b exp=11010", ctrl); end
        n_checks++;
        if (ctrl2 !== 5'b00000) begin n_errors++; $display("FAIL lu_ldfwd_nostall got=%b exp=00000", ctrl2); end
        tick();
        #1;
        n_checks++;
        if (ctrl !== 5'b00000) begin n_errors++; $display("FAIL lu_one_cycle got=%b exp=00000", ctrl); end
        n_checks++;
        if (fwd_a2 !== 2'b11) begin n_errors++; $display("FAIL lu_ldfwd_fwd_a got=%b exp=11", fwd_a2); end
        tick();
        idle();
        #1;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0100) begin n_errors++; $display("FAIL lu_fwd_after got=%b exp=0100", {fwd_a, fwd_b}); end
        n_checks++;
        if (stall_cnt !== 3'd1) begin n_errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        n_checks++;
        if (stall_cnt2 !== 16'd0) begin n_errors++; $display("FAIL lu_ldfwd_stall_cnt got=%0d exp=0", stall_cnt2); end
    endtask

    task automatic test_fwd_priority;
        do_reset();
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0);           // sub x3
        tick();
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 0);           // add x3
        tick();
        set_id(1, 5'd4, 1, 5'd3, 1, 5'd10, 1, 0);          // reader of x4, x3
        tick();
        idle();
        #1;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0010) begin n_errors++; $display("FAIL fwd_mem_over_wb got=%b exp=0010", {fwd_a, fwd_b}); end
        // a non-valid ID slot must not become a producer
        do_reset();
        set_id(0, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0);
        tick();
        set_id(1, 5'd9, 1, 5'd0, 0, 5'd11, 1, 0);
        tick();
        idle();
        #1;
        n_checks++;
        if (fwd_a !== 2'b00) begin n_errors++; $display("FAIL fwd_invalid_id got=%b exp=00", fwd_a); end
    endtask

    task automatic test_redirect_priority;
        do_reset();
        set_id(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);           // lw x5
        tick();
        set_id(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);
        ex_redirect = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 5'b00110) begin n_errors++; $display("FAIL redir_ctrl got=%b exp=00110", ctrl); end
        tick();
        idle();
        #1;
        n_checks++;
        if ({stall_cnt, flush_cnt} !== {3'd0, 3'd1}) begin n_errors++; $display("FAIL redir_cnt stall/flush got=%0d/%0d exp=0/1", stall_cnt, flush_cnt); end
        n_checks++;
        if (ctrl !== 5'b00000) begin n_errors++; $display("FAIL redir_after got=%b exp=00000", ctrl); end
    endtask

    task automatic test_busy;
        do_reset();
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0);           // producer x8
        tick();
        set_id(1, 5'd8, 1, 5'd0, 0, 5'd12, 1, 0);          // reader of x8
        tick();
        set_id(1, 5'd12, 1, 5'd8, 1, 5'd13, 1, 0);
        ex_busy = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (ctrl !== 5'b11001) begin n_errors++; $display("FAIL busy_ctrl cyc=%0d got=%b exp=11001", i, ctrl); end
            n_checks++;
            if (fwd_a !== 2'b10) begin n_errors++; $display("FAIL busy_fwd cyc=%0d got=%b exp=10", i, fwd_a); end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (fwd_a !== 2'b10) begin n_errors++; $display("FAIL busy_shadow_held got=%b exp=10", fwd_a); end
        n_checks++;
        if ({stall_cnt, flush_cnt} !== {3'd4, 3'd0}) begin n_errors++; $display("FAIL busy_cnt stall/flush got=%0d/%0d exp=4/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_x0_and_saturation;
        do_reset();
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);           // writes x0
        tick();
        set_id(1, 5'd0, 1, 5'd0, 1, 5'd14, 1, 0);
        tick();
        idle();
        #1;
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin n_errors++; $display("FAIL x0_no_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
        ex_busy = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        ex_busy = 1'b0;
        #1;
        n_checks++;
        if (stall_cnt !== 3'd7) begin n_errors++; $display("FAIL stall_sat got=%0d exp=7", stall_cnt); end
        ex_redirect = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        ex_redirect = 1'b0;
        #1;
        n_checks++;
        if (flush_cnt !== 3'd7) begin n_errors++; $display("FAIL flush_sat got=%0d exp=7", flush_cnt); end
    endtask

    task automatic test_reset_during_busy;
        do_reset();
        set_id(1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 0);
        tick();
        set_id(1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 0);
        tick();
        ex_busy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        n_checks++;
        if (ctrl !== 5'b00000) begin n_errors++; $display("FAIL rst_busy_ctrl got=%b exp=00000", ctrl); end
        n_checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin n_errors++; $display("FAIL rst_busy_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
        n_checks++;
        if ({stall_cnt, flush_cnt} !== 6'd0) begin n_errors++; $display("FAIL rst_busy_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_redirect_priority();
        test_busy();
        test_x0_and_saturation();
        test_reset_during_busy();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
